// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: command encodings, status bit indices and decode helpers shared by the ALU and arbiter
package alu_arbiter_pkg;

   typedef enum logic [3:0] {
      CMD_NOP = 4'd0,
      CMD_MOV = 4'd1,
      CMD_ADD = 4'd2,
      CMD_ADC = 4'd3,
      CMD_SUB = 4'd4,
      CMD_SBC = 4'd5,
      CMD_AND = 4'd6,
      CMD_ORR = 4'd7,
      CMD_EOR = 4'd8,
      CMD_MVN = 4'd9
   } cmd_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic cmd_ok(input logic [3:0] cmd);
      return cmd != CMD_NOP && cmd <= CMD_MVN;
   endfunction

   // add/sub family: the only commands that produce fresh C and V
   function automatic logic is_arith(input logic [3:0] cmd);
      return cmd == CMD_ADD || cmd == CMD_ADC || cmd == CMD_SUB || cmd == CMD_SBC;
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: combinational 32-bit ALU; C and V are passed through from status_i for non-arithmetic commands
module alu
   import alu_arbiter_pkg::*;
(
   input  logic [3:0]  cmd_i,
   input  logic [31:0] op1_i,
   input  logic [31:0] op2_i,
   input  logic [3:0]  status_i,
   output logic [31:0] result_o,
   output logic [3:0]  status_o,
   output logic        err_o
);

   logic        arith;
   logic        cin;
   logic        ovf;
   logic [31:0] b;
   logic [32:0] sum;

   // one adder serves the whole add/sub family: subtraction is op1 + ~op2 + carry-in
   always_comb begin
      arith = is_arith(cmd_i);
      b = (cmd_i == CMD_SUB || cmd_i == CMD_SBC) ? ~op2_i : op2_i;
      cin = cmd_i == CMD_ADD ? 1'b0 : cmd_i == CMD_SUB ? 1'b1 : status_i[FLAG_C];
      sum = {1'b0, op1_i} + {1'b0, b} + {32'd0, cin};
      ovf = (op1_i[31] == b[31]) & (sum[31] != op1_i[31]);
      err_o = ~cmd_ok(cmd_i);
      case (cmd_i)
         CMD_MOV:                            result_o = op2_i;
         CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: result_o = sum[31:0];
         CMD_AND:                            result_o = op1_i & op2_i;
         CMD_ORR:                            result_o = op1_i | op2_i;
         CMD_EOR:                            result_o = op1_i ^ op2_i;
         CMD_MVN:                            result_o = ~op2_i;
         default:                            result_o = '0;
      endcase
      status_o = '0;
      if (!err_o) begin
         status_o[FLAG_N] = result_o[31];
         status_o[FLAG_Z] = result_o == 32'd0;
         status_o[FLAG_C] = arith ? sum[32] : status_i[FLAG_C];
         status_o[FLAG_V] = arith ? ovf : status_i[FLAG_V];
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through a round-robin grant, per-requester flags and a one-deep output register
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter logic [3:0] STATUS_RESET = 4'b0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_cmd,
   input  logic [31:0] req0_op1,
   input  logic [31:0] req0_op2,
   input  logic        req0_s,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_cmd,
   input  logic [31:0] req1_op1,
   input  logic [31:0] req1_op2,
   input  logic        req1_s,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_id,
   output logic [31:0] out_result,
   output logic [3:0]  out_status,
   output logic        out_err,
   output logic [3:0]  status0,
   output logic [3:0]  status1
);

   logic        run_q;
   logic        last_q, last_d;
   logic        valid_q, valid_d;
   logic        id_q, id_d;
   logic [31:0] result_q, result_d;
   logic [3:0]  st_q, st_d;
   logic        err_q, err_d;
   logic [3:0]  status0_q, status0_d;
   logic [3:0]  status1_q, status1_d;
   logic        can_accept;
   logic        gnt;
   logic        accept;
   logic        wr;
   logic [3:0]  cmd;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        s;
   logic [3:0]  status_in;
   logic [31:0] alu_result;
   logic [3:0]  alu_status;
   logic        alu_err;

   // grant and operand select; run_q keeps both readies low until the first edge after reset release
   always_comb begin
      can_accept = ~valid_q | out_ready;
      gnt = (req0_valid & req1_valid) ? ~last_q : req1_valid;
      accept = run_q & can_accept & (req0_valid | req1_valid);
      req0_ready = accept & ~gnt;
      req1_ready = accept & gnt;
      cmd = gnt ? req1_cmd : req0_cmd;
      op1 = gnt ? req1_op1 : req0_op1;
      op2 = gnt ? req1_op2 : req0_op2;
      s = gnt ? req1_s : req0_s;
      status_in = gnt ? status1_q : status0_q;
   end

   alu u_alu (
      .cmd_i    (cmd),
      .op1_i    (op1),
      .op2_i    (op2),
      .status_i (status_in),
      .result_o (alu_result),
      .status_o (alu_status),
      .err_o    (alu_err)
   );

   // next state: output register reloads on accept, drains on consume; flags written only for the owner
   always_comb begin
      wr = accept & s & ~alu_err;
      valid_d = accept | (valid_q & ~out_ready);
      id_d = accept ? gnt : id_q;
      result_d = accept ? alu_result : result_q;
      st_d = accept ? alu_status : st_q;
      err_d = accept ? alu_err : err_q;
      last_d = accept ? gnt : last_q;
      status0_d = (wr & ~gnt) ? alu_status : status0_q;
      status1_d = (wr & gnt) ? alu_status : status1_q;
   end

   // state registers; last_q resets to 1 so requester 0 wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         last_q <= 1'b1;
         valid_q <= 1'b0;
         id_q <= 1'b0;
         result_q <= '0;
         st_q <= '0;
         err_q <= 1'b0;
         status0_q <= STATUS_RESET;
         status1_q <= STATUS_RESET;
      end else begin
         run_q <= 1'b1;
         last_q <= last_d;
         valid_q <= valid_d;
         id_q <= id_d;
         result_q <= result_d;
         st_q <= st_d;
         err_q <= err_d;
         status0_q <= status0_d;
         status1_q <= status1_d;
      end
   end

   assign out_valid = valid_q;
   assign out_id = id_q;
   assign out_result = result_q;
   assign out_status = st_q;
   assign out_err = err_q;
   assign status0 = status0_q;
   assign status1 = status1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table plus hand sequences, with a reference model feeding a result scoreboard
module tb_alu_arbiter;

   typedef struct {
      logic        v0, v1, s0, s1, ordy;
      logic [3:0]  c0, c1;
      logic [31:0] a0, b0, a1, b1;
      logic [1:0]  rdy;
   } vec_t;

   typedef struct packed {
      logic        id;
      logic [31:0] res;
      logic [3:0]  st;
      logic        err;
   } exp_t;

   logic        clk = 0, rst_n = 0;
   logic        req0_valid, req0_ready, req0_s, req1_valid, req1_ready, req1_s;
   logic [3:0]  req0_cmd, req1_cmd;
   logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic        out_valid, out_ready, out_id, out_err;
   logic [31:0] out_result;
   logic [3:0]  out_status, status0, status1;

   int   checks = 0, fails = 0;
   logic m_valid, m_last;
   logic [3:0] m_st [2];
   exp_t sbq [$];
   vec_t tbl [12];

   alu_arbiter #(.STATUS_RESET(4'b0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
      .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_s(req0_s),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
      .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_s(req1_s),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_result(out_result), .out_status(out_status), .out_err(out_err),
      .status0(status0), .status1(status1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // reference ALU using wide signed/unsigned arithmetic rather than an adder with inverted operand
   function automatic exp_t model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] st);
      exp_t e;
      longint sa, sb, sr, lc;
      logic [32:0] w;
      logic c, v, ar;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lc = longint'({63'd0, st[1]});
      e = '0;
      e.st = st;
      ar = 1'b1;
      c = 1'b0;
      sr = 0;
      case (cmd)
         4'd2: begin w = {1'b0, a} + {1'b0, b}; e.res = w[31:0]; c = w[32]; sr = sa + sb; end
         4'd3: begin w = {1'b0, a} + {1'b0, b} + {32'd0, st[1]}; e.res = w[31:0]; c = w[32]; sr = sa + sb + lc; end
         4'd4: begin e.res = a - b; c = a >= b; sr = sa - sb; end
         4'd5: begin e.res = a - b - {31'd0, !st[1]}; c = {1'b0, a} >= ({1'b0, b} + {32'd0, !st[1]}); sr = sa - sb - (1 - lc); end
         default: begin
            ar = 1'b0;
            case (cmd)
               4'd1: e.res = b;
               4'd6: e.res = a & b;
               4'd7: e.res = a | b;
               4'd8: e.res = a ^ b;
               4'd9: e.res = ~b;
               default: e.err = 1'b1;
            endcase
         end
      endcase
      v = sr > 64'sd2147483647 || sr < -64'sd2147483648;
      if (e.err) begin
         e.res = '0;
         e.st = '0;
      end else begin
         e.st[3] = e.res[31];
         e.st[2] = e.res == 32'd0;
         if (ar) begin
            e.st[1] = c;
            e.st[0] = v;
         end
      end
      return e;
   endfunction

   task automatic apply(input vec_t v);
      req0_valid = v.v0; req0_cmd = v.c0; req0_op1 = v.a0; req0_op2 = v.b0; req0_s = v.s0;
      req1_valid = v.v1; req1_cmd = v.c1; req1_op1 = v.a1; req1_op2 = v.b1; req1_s = v.s1;
      out_ready = v.ordy;
   endtask

   task automatic op(input logic id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic ordy);
      vec_t v;
      v = '{0, 0, 0, 0, ordy, 0, 0, 0, 0, 0, 0, 0};
      if (id) begin v.v1 = 1; v.c1 = c; v.a1 = a; v.b1 = b; v.s1 = s; end
      else begin v.v0 = 1; v.c0 = c; v.a0 = a; v.b0 = b; v.s0 = s; end
      apply(v);
   endtask

   task automatic idle();
      apply('{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
   endtask

   // one clock: check outputs against scoreboard head, predict acceptance, advance to just after the edge
   task automatic step();
      exp_t e;
      logic can, g, acc;
      @(negedge clk);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("status0", {28'd0, status0}, {28'd0, m_st[0]});
      chk("status1", {28'd0, status1}, {28'd0, m_st[1]});
      if (m_valid) begin
         if (sbq.size() == 0) begin
            checks++; fails++;
            $display("FAIL sb_empty actual=out_valid required=no_result");
         end else begin
            e = sbq[0];
            chk("out_id", {31'd0, out_id}, {31'd0, e.id});
            chk("out_result", out_result, e.res);
            chk("out_status", {28'd0, out_status}, {28'd0, e.st});
            chk("out_err", {31'd0, out_err}, {31'd0, e.err});
            if (out_ready) void'(sbq.pop_front());
         end
      end
      can = !m_valid || out_ready;
      g = (req0_valid && req1_valid) ? !m_last : req1_valid;
      acc = can && (req0_valid || req1_valid);
      chk("ready", {30'd0, req1_ready, req0_ready}, {30'd0, acc && g, acc && !g});
      if (acc) begin
         e = g ? model(req1_cmd, req1_op1, req1_op2, m_st[1]) : model(req0_cmd, req0_op1, req0_op2, m_st[0]);
         e.id = g;
         sbq.push_back(e);
         if ((g ? req1_s : req0_s) && !e.err) m_st[g] = e.st;
         m_last = g;
         m_valid = 1;
      end else if (out_ready) m_valid = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      apply('{1, 1, 0, 0, 1, 2, 2, 1, 1, 1, 1, 0});
      rst_n = 0;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_out_id", {31'd0, out_id}, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_status", {28'd0, out_status}, 0);
      chk("rst_out_err", {31'd0, out_err}, 0);
      chk("rst_status0", {28'd0, status0}, 0);
      chk("rst_status1", {28'd0, status1}, 0);
      chk("rst_ready", {30'd0, req1_ready, req0_ready}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      idle();
      rst_n = 1;
      @(posedge clk);
      #1;
      m_valid = 0; m_last = 1; m_st[0] = 0; m_st[1] = 0;
      sbq.delete();
   endtask

   initial begin
      logic [3:0] s0_keep;
      tbl[0]  = '{1, 1, 1, 1, 1, 2, 4, 5, 7, 9, 4, 2'b01};
      tbl[1]  = '{1, 1, 0, 1, 1, 1, 6, 0, 3, 32'hf0f0, 32'h0ff0, 2'b10};
      tbl[2]  = '{1, 1, 1, 0, 1, 4, 2, 3, 8, 1, 1, 2'b01};
      tbl[3]  = '{1, 1, 0, 1, 1, 7, 8, 1, 2, 32'hffff0000, 32'hffffffff, 2'b10};
      tbl[4]  = '{0, 1, 0, 1, 1, 0, 8, 0, 0, 32'haaaa, 32'haaaa, 2'b10};
      tbl[5]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00};
      tbl[6]  = '{1, 0, 1, 0, 0, 2, 0, 32'h7fffffff, 1, 0, 0, 2'b01};
      tbl[7]  = '{1, 1, 1, 1, 0, 2, 2, 1, 1, 1, 1, 2'b00};
      tbl[8]  = '{1, 1, 1, 1, 1, 2, 5, 1, 1, 10, 3, 2'b10};
      tbl[9]  = '{1, 0, 1, 0, 1, 9, 0, 0, 0, 0, 0, 2'b01};
      tbl[10] = '{0, 1, 0, 1, 1, 0, 7, 0, 0, 32'h80000000, 1, 2'b10};
      tbl[11] = '{1, 0, 1, 0, 1, 0, 0, 6, 6, 0, 0, 2'b01};
      idle();
      do_reset();
      op(0, 4'd2, 5, 7, 1, 1);
      step();
      chk("add_result", out_result, 12);
      chk("add_id", {31'd0, out_id}, 0);
      chk("add_status0", {28'd0, status0}, 0);
      idle();
      step();
      do_reset();
      for (int i = 0; i < 12; i++) begin
         apply(tbl[i]);
         #1;
         chk($sformatf("tbl_rdy[%0d]", i), {30'd0, req1_ready, req0_ready}, {30'd0, tbl[i].rdy});
         step();
      end
      idle();
      repeat (2) step();
      s0_keep = m_st[0];
      op(1, 4'd4, 3, 3, 1, 1);
      step();
      op(1, 4'd3, 1, 1, 0, 1);
      step();
      chk("adc_result", out_result, 3);
      chk("sub_status1", {28'd0, status1}, 4'b0110);
      chk("status0_keep", {28'd0, status0}, {28'd0, s0_keep});
      idle();
      step();
      op(0, 4'd2, 10, 20, 0, 0);
      step();
      apply('{1, 1, 0, 0, 0, 6, 7, 3, 5, 4, 8, 0});
      repeat (3) begin
         step();
         chk("stall_rdy", {30'd0, req1_ready, req0_ready}, 0);
         chk("stall_result", out_result, 30);
      end
      out_ready = 1;
      repeat (2) begin
         step();
         chk("no_gap", {31'd0, out_valid}, 1);
      end
      idle();
      repeat (2) step();
      op(1, 4'd2, 1, 2, 0, 0);
      step();
      chk("pre_rst_valid", {31'd0, out_valid}, 1);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("async_valid", {31'd0, out_valid}, 0);
      chk("async_status0", {28'd0, status0}, 0);
      chk("async_status1", {28'd0, status1}, 0);
      chk("async_ready", {30'd0, req1_ready, req0_ready}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      idle();
      rst_n = 1;
      @(posedge clk);
      #1;
      m_valid = 0; m_last = 1; m_st[0] = 0; m_st[1] = 0;
      sbq.delete();
      op(0, 4'd1, 0, 0, 1, 1);
      step();
      op(0, 4'hf, 9, 9, 1, 1);
      step();
      chk("inv_err", {31'd0, out_err}, 1);
      chk("inv_result", out_result, 0);
      chk("inv_status", {28'd0, out_status}, 0);
      idle();
      step();
      chk("inv_status0", {28'd0, status0}, 4'b0100);
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
